// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: key intake, expander load, round-key fetch.
// Optional KE_WAIT timeout enabled by defining AES_KSC_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for key beat 0
// KEY_RX   | collecting key beats 1..3
// KE_START | one-cycle start pulse to expander
// KE_LOAD  | replaying the four buffered key words
// KE_WAIT  | waiting for expander done
// READY    | round keys valid, serving requests or a new key
// FETCH    | reading four words of the requested round
// PRESENT  | holding rk_data until consumer accepts
module aes_key_sched_ctrl #(
  parameter int WAIT_LIMIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [31:0]  key_word,
  output logic         key_ready,
  output logic         ke_start,
  output logic [31:0]  ke_cipher_key,
  output logic [1:0]   ke_r_index,
  output logic [3:0]   ke_round_key_num,
  input  logic [31:0]  ke_round_key,
  input  logic         ke_done,
  output logic         keys_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_num,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, KEY_RX, KE_START, KE_LOAD, KE_WAIT, READY, FETCH, PRESENT
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  beat_cnt, beat_cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [31:0] key_buf [4];
  logic [3:0]  rk_num_q;
  logic        key_acc;
  logic        rk_accept;
  logic        wait_tc;

  // Key beats land in whichever state advertises key_ready.
  assign key_acc = key_valid & ((state == IDLE) | (state == KEY_RX) | (state == READY));

`ifdef AES_KSC_TIMEOUT_EN
  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != KE_WAIT) begin
      wait_cnt <= CW'(WAIT_LIMIT - 1);
    end else if (wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign wait_tc = (wait_cnt == '0);
`else
  logic unused_wait_limit;
  assign unused_wait_limit = (WAIT_LIMIT != 0);
  assign wait_tc = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= 2'd0;
      idx      <= 2'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      idx      <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) key_buf[i] <= 32'h0;
      rk_num_q <= 4'd0;
      rk_data  <= 128'h0;
    end else begin
      if (key_acc) begin
        key_buf[(state == KEY_RX) ? beat_cnt : 2'd0] <= key_word;
      end
      if (rk_accept) begin
        rk_num_q <= rk_num;
      end
      if (state == FETCH) begin
        case (idx)
          2'd0: rk_data[127:96] <= ke_round_key;
          2'd1: rk_data[95:64]  <= ke_round_key;
          2'd2: rk_data[63:32]  <= ke_round_key;
          default: rk_data[31:0] <= ke_round_key;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    beat_cnt_nxt     = beat_cnt;
    idx_nxt          = idx;
    key_ready        = 1'b0;
    ke_start         = 1'b0;
    ke_cipher_key    = 32'h0;
    ke_r_index       = 2'd0;
    ke_round_key_num = 4'd0;
    keys_ready       = 1'b0;
    rk_valid         = 1'b0;
    err              = 1'b0;
    rk_accept        = 1'b0;
    case (state)
      IDLE: begin
        key_ready = ~reset;
        if (key_valid) begin
          state_nxt    = KEY_RX;
          beat_cnt_nxt = 2'd1;
        end
      end
      KEY_RX: begin
        key_ready = ~reset;
        if (key_valid) begin
          beat_cnt_nxt = beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state_nxt = KE_START;
        end
      end
      KE_START: begin
        ke_start  = 1'b1;
        idx_nxt   = 2'd0;
        state_nxt = KE_LOAD;
      end
      KE_LOAD: begin
        ke_cipher_key = key_buf[idx];
        idx_nxt       = idx + 2'd1;
        if (idx == 2'd3) state_nxt = KE_WAIT;
      end
      KE_WAIT: begin
        if (ke_done) begin
          state_nxt = READY;
        end else if (wait_tc) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      READY: begin
        key_ready  = ~reset;
        keys_ready = 1'b1;
        // A new key wins over a simultaneous round-key request.
        if (key_valid) begin
          state_nxt    = KEY_RX;
          beat_cnt_nxt = 2'd1;
        end else if (rk_req) begin
          if (rk_num <= 4'd10) begin
            rk_accept = 1'b1;
            idx_nxt   = 2'd0;
            state_nxt = FETCH;
          end else begin
            err = 1'b1;
          end
        end
      end
      FETCH: begin
        keys_ready       = 1'b1;
        ke_round_key_num = rk_num_q;
        ke_r_index       = idx;
        idx_nxt          = idx + 2'd1;
        if (idx == 2'd3) state_nxt = PRESENT;
      end
      PRESENT: begin
        keys_ready = 1'b1;
        rk_valid   = 1'b1;
        if (rk_ready) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural FIPS-197 expander.
// Timeout scenario runs only when AES_KSC_TIMEOUT_EN is defined.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [31:0]  key_word;
  logic         key_ready;
  logic         ke_start;
  logic [31:0]  ke_cipher_key;
  logic [1:0]   ke_r_index;
  logic [3:0]   ke_round_key_num;
  logic [31:0]  ke_round_key;
  logic         ke_done = 1'b0;
  logic         keys_ready;
  logic         rk_req;
  logic [3:0]   rk_num;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic         err;

  localparam logic [127:0] KEY1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] sb_q [$];

  aes_key_sched_ctrl #(.WAIT_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_word(key_word), .key_ready(key_ready),
    .ke_start(ke_start), .ke_cipher_key(ke_cipher_key), .ke_r_index(ke_r_index),
    .ke_round_key_num(ke_round_key_num), .ke_round_key(ke_round_key), .ke_done(ke_done),
    .keys_ready(keys_ready), .rk_req(rk_req), .rk_num(rk_num),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural expander
  logic [7:0]  sbox [256];
  logic [31:0] w [44];
  logic [31:0] cap [4];
  bit          loading = 0;
  bit          block_done = 0;
  int          ld_cnt = 0;
  int          done_dly = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h0;
      if (x != 0) begin
        inv = 8'h1;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key();
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = cap[i];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  always @(posedge clk) begin
    if (ke_start) begin
      loading  = 1;
      ld_cnt   = 0;
      done_dly = 0;
      ke_done <= 1'b0;
    end else if (loading) begin
      cap[ld_cnt] = ke_cipher_key;
      ld_cnt++;
      if (ld_cnt == 4) begin
        loading = 0;
        expand_key();
        done_dly = 3;
      end
    end else if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0 && !block_done) ke_done <= 1'b1;
    end
  end

  assign ke_round_key = (ke_round_key_num <= 4'd10) ? w[ke_round_key_num * 4 + ke_r_index] : 32'h0;

  // Drives four beats; returns at negedge+1 of the cycle after the last beat.
  task automatic send_beats(input logic [127:0] key, input int gap, input bit with_req);
    for (int b = 0; b < 4; b++) begin
      key_valid = 1'b0;
      repeat (gap) @(negedge clk);
      #1;
      key_valid = 1'b1;
      key_word  = key[127 - 32*b -: 32];
      if (with_req && b == 0) begin
        rk_req = 1'b1;
        rk_num = 4'd2;
      end
      #1;
      check("beat_ready", key_ready, 1'b1);
      @(negedge clk);
      rk_req = 1'b0;
      #1;
      if (with_req && b == 0) begin
        check("prio_keys_ready", keys_ready, 1'b0);
        check("prio_no_fetch", key_ready, 1'b1);
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] key, input int gap, input bit with_req);
    int n;
    send_beats(key, gap, with_req);
    check("start_pulse", ke_start, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("start_single", ke_start, 1'b0);
      check("load_word", ke_cipher_key, key[127 - 32*i -: 32]);
    end
    @(negedge clk); #1;
    check("wait_word_zero", ke_cipher_key, 32'h0);
    n = 0;
    while (!ke_done && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", ke_done, 1'b1);
    check("keys_ready_pre", keys_ready, 1'b0);
    @(negedge clk); #1;
    check("keys_ready_rise", keys_ready, 1'b1);
  endtask

  task automatic req_round(input logic [3:0] n, input logic [127:0] exp, input int stall);
    logic [127:0] e;
    sb_q.push_back(exp);
    rk_req = 1'b1;
    rk_num = n;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rk_req = 1'b0;
      #1;
      check("rk_valid_lat", rk_valid, (i == 5));
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      check("stall_valid", rk_valid, 1'b1);
      check("stall_data", rk_data, sb_q[0]);
    end
    rk_ready = 1'b1;
    e = sb_q.pop_front();
    check("rk_data", rk_data, e);
    @(negedge clk);
    rk_ready = 1'b0;
    #1;
    check("rk_valid_drop", rk_valid, 1'b0);
    check("keys_ready_hold", keys_ready, 1'b1);
  endtask

  initial begin
    int starts;
    build_sbox();
    reset = 1'b1; key_valid = 1'b0; key_word = 32'h0;
    rk_req = 1'b0; rk_num = 4'd0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_key_ready", key_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("idle_key_ready", key_ready, 1'b1);
    check("rst_ke_start", ke_start, 1'b0);
    check("rst_cipher_key", ke_cipher_key, 32'h0);
    check("rst_r_index", ke_r_index, 2'd0);
    check("rst_round_num", ke_round_key_num, 4'd0);
    check("rst_keys_ready", keys_ready, 1'b0);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_rk_data", rk_data, 128'h0);
    check("rst_err", err, 1'b0);

    load_key(KEY1, 2, 1'b0);
    req_round(4'd1, KEY1_R1, 3);
    req_round(4'd10, KEY1_R10, 3);

    // Out-of-range round
    rk_req = 1'b1;
    rk_num = 4'd11;
    #1;
    check("bad_req_err", err, 1'b1);
    @(negedge clk);
    rk_req = 1'b0;
    #1;
    check("bad_req_err_once", err, 1'b0);
    check("bad_req_stay_ready", key_ready, 1'b1);
    check("bad_req_no_fetch", rk_valid, 1'b0);
    req_round(4'd0, KEY1, 0);

    // Key beat and request together: key wins
    load_key(KEY2, 0, 1'b1);
    req_round(4'd10, KEY2_R10, 1);

    // Reset during KE_LOAD
    send_beats(KEY1, 1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_key_ready", key_ready, 1'b0);
    check("midrst_keys_ready", keys_ready, 1'b0);
    check("midrst_cipher_key", ke_cipher_key, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ke_start) starts++;
      @(negedge clk);
    end
    #1;
    check("midrst_no_start", starts, 0);
    check("midrst_idle", key_ready, 1'b1);

`ifdef AES_KSC_TIMEOUT_EN
    begin
      int cyc;
      block_done = 1;
      send_beats(KEY2, 0, 1'b0);
      cyc = 1;
      while (!err && cyc < 200) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("timeout_err", err, 1'b1);
      check("timeout_cycle", cyc, 69);
      @(negedge clk); #1;
      check("timeout_err_once", err, 1'b0);
      check("timeout_idle", key_ready, 1'b1);
      check("timeout_keys_ready", keys_ready, 1'b0);
      block_done = 0;
    end
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
